// File: rtl/shared_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shared_pkg
// Description : Shared types for the SPI RAM arbiter slice. Holds the SPI
//               command opcodes and the arbiter FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package shared_pkg;

  // SPI command opcodes carried in rx_data[9:8]
  typedef enum logic [1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } spi_cmd_e;

  // Arbiter FSM states. The ARB_ prefix keeps these apart from the SPI
  // slave's own state enum when both are imported into one scope.
  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_e;

endpackage : shared_pkg
`default_nettype wire

// File: rtl/spi_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module      : spi_cmd_decoder
// Description : Decodes the 10-bit SPI command stream. Holds the write and
//               read address registers, a one-entry pending access register
//               and the sticky overflow flag.
// Ports       : clk, rst_n           - clock, async active-low reset
//               rx_data, rx_valid    - SPI command and strobe
//               spi_gnt              - arbiter consumes the pending entry
//               pend_valid/we/addr/wdata - pending access snapshot
//               spi_ovf              - sticky: an access command was dropped
// Revision    : 1.0 - initial release
// ============================================================================
module spi_cmd_decoder
  import shared_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [9:0]            rx_data,
  input  logic                  rx_valid,
  input  logic                  spi_gnt,
  output logic                  pend_valid,
  output logic                  pend_we,
  output logic [ADDR_WIDTH-1:0] pend_addr,
  output logic [DATA_WIDTH-1:0] pend_wdata,
  output logic                  spi_ovf
);

  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  pend_valid_q, pend_valid_d;
  logic                  pend_we_q, pend_we_d;
  logic [ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;
  logic [DATA_WIDTH-1:0] pend_wdata_q, pend_wdata_d;
  logic                  spi_ovf_q, spi_ovf_d;
  spi_cmd_e              cmd;

  always_comb begin
    cmd          = spi_cmd_e'(rx_data[9:8]);
    wr_addr_d    = wr_addr_q;
    rd_addr_d    = rd_addr_q;
    pend_valid_d = pend_valid_q;
    pend_we_d    = pend_we_q;
    pend_addr_d  = pend_addr_q;
    pend_wdata_d = pend_wdata_q;
    spi_ovf_d    = spi_ovf_q;

    if (spi_gnt) begin
      pend_valid_d = 1'b0;
    end

    if (rx_valid) begin
      case (cmd)
        WR_ADDR: wr_addr_d = ADDR_WIDTH'(rx_data[7:0]);
        RD_ADDR: rd_addr_d = ADDR_WIDTH'(rx_data[7:0]);
        WR_DATA, RD_DATA: begin
          // The slot frees up in the same cycle it is granted, so a command
          // arriving alongside the grant still fits.
          if (!pend_valid_q || spi_gnt) begin
            pend_valid_d = 1'b1;
            // Snapshot address and data now so later address loads cannot
            // retarget an access that is already queued.
            if (cmd == WR_DATA) begin
              pend_we_d    = 1'b1;
              pend_addr_d  = wr_addr_q;
              pend_wdata_d = DATA_WIDTH'(rx_data[7:0]);
            end else begin
              pend_we_d    = 1'b0;
              pend_addr_d  = rd_addr_q;
              pend_wdata_d = '0;
            end
          end else begin
            spi_ovf_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr_q    <= '0;
      rd_addr_q    <= '0;
      pend_valid_q <= 1'b0;
      pend_we_q    <= 1'b0;
      pend_addr_q  <= '0;
      pend_wdata_q <= '0;
      spi_ovf_q    <= 1'b0;
    end else begin
      wr_addr_q    <= wr_addr_d;
      rd_addr_q    <= rd_addr_d;
      pend_valid_q <= pend_valid_d;
      pend_we_q    <= pend_we_d;
      pend_addr_q  <= pend_addr_d;
      pend_wdata_q <= pend_wdata_d;
      spi_ovf_q    <= spi_ovf_d;
    end
  end

  assign pend_valid = pend_valid_q;
  assign pend_we    = pend_we_q;
  assign pend_addr  = pend_addr_q;
  assign pend_wdata = pend_wdata_q;
  assign spi_ovf    = spi_ovf_q;

endmodule : spi_cmd_decoder
`default_nettype wire

// File: rtl/spi_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : spi_ram_arbiter
// Description : Shares a single-port RAM between the SPI command stream and
//               a local host port. SPI wins ties; with SPI_ARB_FAIR_EN
//               defined, a host that has lost MAX_WAIT decisions in a row
//               wins the next one. Without the macro SPI priority is strict.
// Ports       : clk, rst_n                 - clock, async active-low reset
//               rx_data/rx_valid           - SPI command input
//               tx_data/tx_valid           - SPI read data (level valid)
//               host_req/we/addr/wdata     - host request (held until gnt)
//               host_gnt, host_rvalid/rdata - host grant and read return
//               ram_en/we/addr/wdata/rdata - RAM macro interface
//               busy, spi_ovf              - status
// Config      : SPI_ARB_FAIR_EN - enables the host starvation guard
// Revision    : 1.0 - initial release
// ============================================================================
module spi_ram_arbiter
  import shared_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_WAIT   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [9:0]            rx_data,
  input  logic                  rx_valid,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic                  host_gnt,
  output logic                  host_rvalid,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  busy,
  output logic                  spi_ovf
);

  logic                  spi_pend, spi_pend_we, spi_gnt, host_win;
  logic [ADDR_WIDTH-1:0] spi_pend_addr;
  logic [DATA_WIDTH-1:0] spi_pend_wdata;

  arb_state_e            state_q, state_d;
  logic                  ram_en_q, ram_en_d, ram_we_q, ram_we_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
  logic                  host_gnt_q, host_gnt_d;
  logic                  resp_host_q, resp_host_d;  // current read belongs to host
  logic                  tx_valid_q, tx_valid_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  host_rvalid_q, host_rvalid_d;
  logic [DATA_WIDTH-1:0] host_rdata_q, host_rdata_d;

  spi_cmd_decoder #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_dec (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .spi_gnt    (spi_gnt),
    .pend_valid (spi_pend),
    .pend_we    (spi_pend_we),
    .pend_addr  (spi_pend_addr),
    .pend_wdata (spi_pend_wdata),
    .spi_ovf    (spi_ovf)
  );

`ifdef SPI_ARB_FAIR_EN
  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);
  logic [3:0] host_wait_q, host_wait_d;

  assign host_win = host_req && (!spi_pend || (host_wait_q == MAX_WAIT_C));

  // Counts consecutive decisions the host loses; only moves on decisions.
  always_comb begin
    host_wait_d = host_wait_q;
    if ((state_q == ARB_IDLE) && host_req) begin
      if (host_win) begin
        host_wait_d = '0;
      end else if (host_wait_q != MAX_WAIT_C) begin
        host_wait_d = host_wait_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) host_wait_q <= '0;
    else        host_wait_q <= host_wait_d;
  end
`else
  logic unused_max_wait;
  assign unused_max_wait = ^(4'(MAX_WAIT));
  assign host_win        = host_req && !spi_pend;
`endif

  always_comb begin
    state_d       = state_q;
    ram_en_d      = 1'b0;
    ram_we_d      = 1'b0;
    ram_addr_d    = ram_addr_q;
    ram_wdata_d   = ram_wdata_q;
    host_gnt_d    = 1'b0;
    resp_host_d   = resp_host_q;
    tx_valid_d    = tx_valid_q;
    tx_data_d     = tx_data_q;
    host_rvalid_d = 1'b0;
    host_rdata_d  = host_rdata_q;
    spi_gnt       = 1'b0;

    // Any SPI command retires the previous read result.
    if (rx_valid) tx_valid_d = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (spi_pend || host_req) begin
          state_d     = ARB_ACCESS;
          ram_en_d    = 1'b1;
          resp_host_d = host_win;
          if (host_win) begin
            host_gnt_d  = 1'b1;
            ram_we_d    = host_we;
            ram_addr_d  = host_addr;
            ram_wdata_d = host_wdata;
          end else begin
            spi_gnt     = 1'b1;
            ram_we_d    = spi_pend_we;
            ram_addr_d  = spi_pend_addr;
            ram_wdata_d = spi_pend_wdata;
          end
        end
      end
      ARB_ACCESS: state_d = ram_we_q ? ARB_IDLE : ARB_RESP;
      ARB_RESP: begin
        state_d = ARB_IDLE;
        if (resp_host_q) begin
          host_rvalid_d = 1'b1;
          host_rdata_d  = ram_rdata;
        end else begin
          // New read data takes precedence over a same-cycle clear.
          tx_valid_d = 1'b1;
          tx_data_d  = 8'(ram_rdata);
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ARB_IDLE;
      ram_en_q      <= 1'b0;
      ram_we_q      <= 1'b0;
      ram_addr_q    <= '0;
      ram_wdata_q   <= '0;
      host_gnt_q    <= 1'b0;
      resp_host_q   <= 1'b0;
      tx_valid_q    <= 1'b0;
      tx_data_q     <= '0;
      host_rvalid_q <= 1'b0;
      host_rdata_q  <= '0;
    end else begin
      state_q       <= state_d;
      ram_en_q      <= ram_en_d;
      ram_we_q      <= ram_we_d;
      ram_addr_q    <= ram_addr_d;
      ram_wdata_q   <= ram_wdata_d;
      host_gnt_q    <= host_gnt_d;
      resp_host_q   <= resp_host_d;
      tx_valid_q    <= tx_valid_d;
      tx_data_q     <= tx_data_d;
      host_rvalid_q <= host_rvalid_d;
      host_rdata_q  <= host_rdata_d;
    end
  end

  assign ram_en      = ram_en_q;
  assign ram_we      = ram_we_q;
  assign ram_addr    = ram_addr_q;
  assign ram_wdata   = ram_wdata_q;
  assign host_gnt    = host_gnt_q;
  assign host_rvalid = host_rvalid_q;
  assign host_rdata  = host_rdata_q;
  assign tx_valid    = tx_valid_q;
  assign tx_data     = tx_data_q;
  assign busy        = (state_q != ARB_IDLE) || spi_pend || host_req;

endmodule : spi_ram_arbiter
`default_nettype wire

// File: doc/spi_ram_arbiter.md
# spi_ram_arbiter

Sequences and shares the single-port RAM between two requesters: the SPI slave's 10-bit command stream (`rx_data`/`rx_valid`, `tx_data`/`tx_valid`) and a local host port. The block decodes SPI commands, holds the write/read address registers, arbitrates each RAM cycle (SPI priority with a host starvation guard), and returns read data to the correct requester. It sits between the SPI slave and the RAM macro.

## Interface
- `ADDR_WIDTH`, 8, RAM address width
- `DATA_WIDTH`, 8, RAM data width
- `MAX_WAIT`, 4, consecutive lost arbitrations after which the host wins (1..15)

Ports:
- `clk` in 1: single clock, all logic on posedge.
- `rst_n` in 1: asynchronous, active-low reset.
- `rx_data` in 10: SPI command; [9:8] opcode, [7:0] payload.
- `rx_valid` in 1: one-cycle strobe, `rx_data` valid.
- `tx_data` out 8: SPI read data.
- `tx_valid` out 1: `tx_data` valid; level signal.
- `host_req` in 1: host access request; held with fields stable until `host_gnt`.
- `host_we` in 1: 1 = write, 0 = read.
- `host_addr` in ADDR_WIDTH: host address.
- `host_wdata` in DATA_WIDTH: host write data.
- `host_gnt` out 1: one-cycle grant pulse.
- `host_rvalid` out 1: one-cycle pulse, `host_rdata` valid.
- `host_rdata` out DATA_WIDTH: host read data.
- `ram_en` out 1: RAM access strobe.
- `ram_we` out 1: RAM write enable.
- `ram_addr` out ADDR_WIDTH: RAM address.
- `ram_wdata` out DATA_WIDTH: RAM write data.
- `ram_rdata` in DATA_WIDTH: RAM read data; valid one cycle after a read `ram_en`.
- `busy` out 1: FSM not in ARB_IDLE, or any request pending.
- `spi_ovf` out 1: sticky; an SPI access command was dropped.

## Operation
- Reset value of every output is 0. Address registers, pending flag and wait counter are also 0. Reset mid-access aborts it asynchronously: `ram_en` drops, the pending request is lost, and no response is issued.
- SPI opcodes:
  - 00 WR_ADDR: `wr_addr` ← payload; no RAM cycle.
  - 01 WR_DATA: enqueue write of payload to `wr_addr`.
  - 10 RD_ADDR: `rd_addr` ← payload; no RAM cycle.
  - 11 RD_DATA: enqueue read of `rd_addr`; payload ignored.
- SPI pending register: one entry. It captures the op, the address and the data at enqueue time, so a later address load does not alter a queued access.
  - WR_DATA/RD_DATA arriving while pending is set and not granted that cycle: the command is dropped and `spi_ovf` is set.
  - Arrival in the same cycle as the grant of the pending entry: the new command is accepted.
- `tx_valid` rises with read data and holds until the next `rx_valid` of any opcode, which clears it in the following cycle.
- FSM states:
  - ARB_IDLE: if any request is pending, pick a winner, register the `ram_*` outputs, and go to ARB_ACCESS. Otherwise stay.
  - ARB_ACCESS: `ram_en`=1 for exactly one cycle. `host_gnt`=1 in this cycle if the host won. Reads go to ARB_RESP; writes go to ARB_IDLE.
  - ARB_RESP: capture `ram_rdata`. Next cycle, assert `tx_valid` with `tx_data`, or pulse `host_rvalid` with `host_rdata`. Then go to ARB_IDLE.
- Arbitration, evaluated in ARB_IDLE only:
  - SPI wins on a tie.
  - `host_wait` increments each decision in which the host is pending but loses. It saturates at `MAX_WAIT` and clears on host grant.
  - When `host_wait` == `MAX_WAIT`, the host wins.

## Timing
- Uncontested SPI write: `rx_valid` in cycle 0; pending in cycle 1 (decision); `ram_en`/`ram_we` in cycle 2.
- Uncontested SPI read: same as the write through cycle 2, then ARB_RESP in cycle 3 and `tx_valid`=1 from cycle 4.
- Host: `host_req` seen in ARB_IDLE in cycle n; `host_gnt` and `ram_en` in cycle n+1; for a read, `host_rvalid` in cycle n+3.
- Throughput: a write occupies 2 cycles, a read 3 cycles. No RAM cycles are overlapped.

## Configuration
- `SPI_ARB_FAIR_EN`:
  - Defined: the starvation guard is as above.
  - Undefined: strict SPI priority; `host_wait` logic is absent and `MAX_WAIT` is ignored.

## Structure
- `shared_pkg` holds:
  - `spi_cmd_e` (WR_ADDR=2'b00, WR_DATA=2'b01, RD_ADDR=2'b10, RD_DATA=2'b11).
  - `arb_state_e` (ARB_IDLE, ARB_ACCESS, ARB_RESP). The ARB_ prefix avoids clashing with the SPI FSM enum.
- Sub-module `spi_cmd_decoder`: holds `rx_data` decode, the `wr_addr`/`rd_addr` registers, the pending register and `spi_ovf`. The top level holds the arbiter FSM and the response path.

## Test plan
- Reset mid-ARB_ACCESS: assert `rst_n`=0 during an SPI write → all outputs 0 immediately; no `tx_valid` and no `host_rvalid` afterwards.
- SPI write then read back: 0x000A, 0x0155, 0x020A, 0x0300 → RAM[0x0A]=0x55; `tx_data`=0x55 with `tx_valid`=1, 4 cycles after the last `rx_valid`.
- Address isolation: 0x0010, 0x01AA, then 0x0020 immediately → write lands at 0x10, not 0x20.
- Overflow: hold `host_req` so the FSM is busy; send 0x0311 then 0x0322 before the first is granted → `spi_ovf`=1; only one read is performed.
- Starvation (macro defined, MAX_WAIT=4): continuous SPI RD_DATA plus a host write 0x3C→0x40 → `host_gnt` after exactly 4 lost decisions; RAM[0x40]=0x3C.
- Macro undefined with the same stimulus → no `host_gnt` while SPI requests are continuous.
